// File: rtl/hex_display_driver.sv
// Multi-digit hexadecimal seven-segment driver.
// Captures a packed nibble value on load, then drives registered segment codes
// with leading-zero blanking, per-digit enable, per-digit blinking and a load
// acknowledge that coincides with the first cycle showing the new value.
module hex_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    load_ack
);

  localparam int               CNT_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]       BLANK_CODE = ACTIVE_LOW ? 7'h7F : 7'h00;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] decode_low(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'b1000000;
      4'h1:    code = 7'b1111001;
      4'h2:    code = 7'b0100100;
      4'h3:    code = 7'b0110000;
      4'h4:    code = 7'b0011001;
      4'h5:    code = 7'b0010010;
      4'h6:    code = 7'b0000010;
      4'h7:    code = 7'b1111000;
      4'h8:    code = 7'b0000000;
      4'h9:    code = 7'b0010000;
      4'hA:    code = 7'b0001000;
      4'hB:    code = 7'b0000011;
      4'hC:    code = 7'b1000110;
      4'hD:    code = 7'b0100001;
      4'hE:    code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
    return code;
  endfunction

  // Converts an active-low pattern to the board's drive polarity.
  function automatic logic [6:0] apply_polarity(input logic [6:0] code_low);
    return ACTIVE_LOW ? code_low : ~code_low;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_p1;
  logic                    vld_p1;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;
  logic [7*NUM_DIGITS-1:0] seg_next;

  // ---- stage 1: capture the value and remember that a load happened ----
  // Capture register and pending-acknowledge flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      if (load) value_p1 <= value;
      vld_p1 <= load;
    end
  end

  // Free-running blink divider; a load restarts it so fresh data shows lit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (load) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CNT_W'(1);
    end
  end

  // Per-digit decode with enable, blink and leading-zero blanking; the scan
  // runs from the top digit down so "all higher digits zero" accumulates.
  always_comb begin
    logic upper_zero;
    logic blank;
    seg_next   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (value_p1[4*i +: 4] == 4'h0);
      blank = !digit_en[i] || (blink_mask[i] && blink_phase) ||
              (blank_lz && (i != 0) && upper_zero);
      seg_next[7*i +: 7] = blank ? BLANK_CODE : apply_polarity(decode_low(value_p1[4*i +: 4]));
    end
  end

  // ---- stage 2: registered segment outputs and load acknowledge ----
  // Output register; reset shows every digit blank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg      <= {NUM_DIGITS{BLANK_CODE}};
      load_ack <= 1'b0;
    end else begin
      seg      <= seg_next;
      load_ack <= vld_p1;
    end
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: two instances (active-low and active-high
// polarity) share stimulus; a behavioural model predicts the outputs each cycle.
module tb_hex_display_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [15:0]   value      = 16'h1234;
  logic          load       = 1'b1;
  logic [ND-1:0] digit_en   = 4'hF;
  logic          blank_lz   = 1'b0;
  logic [ND-1:0] blink_mask = 4'h0;
  logic [27:0]   seg, seg_hi;
  logic          load_ack, load_ack_hi;

  int checks = 0;
  int passed = 0;
  bit checking = 1'b0;

  // Model state: loaded value, edges since the divider last sat at zero,
  // whether the previous edge was a load, and the predicted outputs.
  logic [15:0] m_val   = 16'h0;
  int          m_n     = 0;
  bit          m_pend  = 1'b0;
  logic [27:0] exp_seg = 28'hFFFFFFF;
  logic        exp_ack = 1'b0;

  hex_display_driver #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load),
    .digit_en(digit_en), .blank_lz(blank_lz), .blink_mask(blink_mask),
    .seg(seg), .load_ack(load_ack));

  hex_display_driver #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load),
    .digit_en(digit_en), .blank_lz(blank_lz), .blink_mask(blink_mask),
    .seg(seg_hi), .load_ack(load_ack_hi));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask

  // Expected active-low display for a value and live controls.
  function automatic logic [27:0] model_seg(input logic [15:0] v, input logic [3:0] en,
                                            input logic lz, input logic [3:0] mask,
                                            input bit ph);
    logic [27:0] r;
    bit blank;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      blank = (en[i] == 1'b0) || (mask[i] && ph) || (lz && i > 0 && (v >> (4*i)) == 16'h0);
      r[7*i +: 7] = blank ? 7'h7F : DEC[v[4*i +: 4]];
    end
    return r;
  endfunction

  // Behavioural model: blink phase is the parity of whole half-periods elapsed.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_val = 16'h0; m_n = 0; m_pend = 1'b0;
      exp_seg = 28'hFFFFFFF; exp_ack = 1'b0;
    end else begin
      exp_seg = model_seg(m_val, digit_en, blank_lz, blink_mask, ((m_n / DIV) % 2) == 1);
      exp_ack = m_pend;
      if (load) begin m_val = value; m_n = 0; m_pend = 1'b1; end
      else begin m_n++; m_pend = 1'b0; end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("seg_model", seg, exp_seg);
      check("seg_hi_model", seg_hi, ~exp_seg);
      check("ack_model", {27'b0, load_ack}, {27'b0, exp_ack});
      check("ack_hi_model", {27'b0, load_ack_hi}, {27'b0, exp_ack});
    end
  end

  initial begin
    // Reset held with load high.
    repeat (3) @(negedge clk);
    check("reset_seg", seg, 28'hFFFFFFF);
    check("reset_seg_hi", seg_hi, 28'h0);
    check("reset_ack", {27'b0, load_ack}, 28'h0);
    checking = 1'b1;
    reset_n = 1'b1; load = 1'b0; value = 16'h0;
    @(negedge clk);
    check("post_reset_zeros", seg, {4{7'b1000000}});

    // Single load and its latency.
    value = 16'h1A2F; load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("ack_not_early", {27'b0, load_ack}, 28'h0);
    @(negedge clk);
    check("load_1a2f", seg, {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110});
    check("ack_1a2f", {27'b0, load_ack}, 28'h1);
    @(negedge clk);
    check("ack_one_cycle", {27'b0, load_ack}, 28'h0);

    // Back-to-back loads.
    value = 16'h0001; load = 1'b1;
    @(negedge clk); value = 16'h0002;
    @(negedge clk); load = 1'b0;
    check("b2b_first", seg, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001});
    check("b2b_ack1", {27'b0, load_ack}, 28'h1);
    @(negedge clk);
    check("b2b_second", seg, {7'b1000000, 7'b1000000, 7'b1000000, 7'b0100100});
    check("b2b_ack2", {27'b0, load_ack}, 28'h1);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    value = 16'h0050; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    check("lz_0050", seg, {7'h7F, 7'h7F, 7'b0010010, 7'b1000000});
    value = 16'h0000; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    check("lz_0000", seg, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    value = 16'h0100; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    check("lz_0100", seg, {7'h7F, 7'b1111001, 7'b1000000, 7'b1000000});
    blank_lz = 1'b0;

    // Per-digit enable with one-cycle response.
    value = 16'h1A2F; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    digit_en = 4'b0101;
    @(negedge clk);
    check("enable_0101", seg, {7'h7F, 7'b0001000, 7'h7F, 7'b0001110});
    digit_en = 4'hF;

    // Polarity: all-eights lights every segment.
    value = 16'h8888; load = 1'b1; @(negedge clk); load = 1'b0; @(negedge clk);
    check("eights_low", seg, 28'h0);
    check("eights_high", seg_hi, 28'hFFFFFFF);

    // Blink with a load landing on the divider wrap.
    blink_mask = 4'b0010; value = 16'h4321; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int j = 0; j < DIV; j++) begin
      @(negedge clk);
      check("blink_lit_after_wrap_load", {21'b0, seg[13:7]}, {21'b0, 7'b0100100});
    end
    @(negedge clk);
    check("blink_blank", {21'b0, seg[13:7]}, {21'b0, 7'h7F});
    check("blink_other_digits", {7'b0, seg[27:14], seg[6:0]}, {7'b0, 7'b0011001, 7'b0110000, 7'b1111001});

    // Asynchronous reset right after a load edge, while blinking.
    value = 16'h5A5A; load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0; reset_n = 1'b0;
    #1;
    check("async_seg", seg, 28'hFFFFFFF);
    check("async_seg_hi", seg_hi, 28'h0);
    check("async_ack", {27'b0, load_ack}, 28'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1; blink_mask = 4'h0;
    @(negedge clk);
    check("ack_suppressed", {27'b0, load_ack}, 28'h0);
    check("after_async_zeros", seg, {4{7'b1000000}});

    // Randomised traffic with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      value = 16'($urandom);
      if ($urandom_range(0, 1) == 1) value = value >> (4 * $urandom_range(0, 3));
      load = ($urandom_range(0, 3) == 0);
      digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      blank_lz = 1'($urandom);
      blink_mask = 4'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        #2 reset_n = 1'b0;
        #1 check("rand_async_seg", seg, 28'hFFFFFFF);
        check("rand_async_ack", {27'b0, load_ack}, 28'h0);
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
